sev_seg_scan_driver: RTL and testbench

SEV_SEG_SCAN_DRIVER -- requirements
Module: sev_seg_scan_driver

---
 rtl/sev_seg_scan_driver.sv | 99 +++++++++
 tb/tb_sev_seg_scan_driver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sev_seg_scan_driver.sv
// rtl/sev_seg_scan_driver.sv - multiplexed 4-digit seven-segment scan driver
// Define SEV_SEG_GHOST_BLANK_EN to hold the digit selects off for BLANK_CYCLES at each slot start.
module sev_seg_scan_driver #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] digit_0,
    input  logic [6:0] digit_1,
    input  logic [6:0] digit_2,
    input  logic [6:0] digit_3,
    input  logic [3:0] dots,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_sel,
    output logic       frame_start
);

    localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [6:0]    SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0]    SEL_OFF  = {4{SEL_ACTIVE_LOW}};
`ifdef SEV_SEG_GHOST_BLANK_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    slot, slot_n;
    logic          shown, shown_n;
    logic          tick;
    logic [6:0]    pat;
    logic          pat_dp;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [3:0]    sel_n;
    logic          sel_on;
    logic          fs_n;

    always_comb begin
        tick    = (cnt == CNT_LAST);
        cnt_n   = tick ? '0 : cnt + 1'b1;
        slot_n  = tick ? slot + 2'd1 : slot;
        // A slot is only displayed if en was high at its opening edge and has stayed high.
        shown_n = tick ? en : (shown & en);
        fs_n    = tick & (slot == 2'd3);

        pat = digit_0;
        case (slot_n)
            2'd1:    pat = digit_1;
            2'd2:    pat = digit_2;
            2'd3:    pat = digit_3;
            default: pat = digit_0;
        endcase
        pat_dp = dots[slot_n];

        seg_n = seg;
        dp_n  = dp;
        if (!shown_n) begin
            seg_n = SEG_OFF;
            dp_n  = SEG_ACTIVE_LOW;
        end else if (tick) begin
            seg_n = pat ^ SEG_OFF;
            dp_n  = pat_dp ^ SEG_ACTIVE_LOW;
        end

`ifdef SEV_SEG_GHOST_BLANK_EN
        // Next prescaler value is cnt+1 off-tick, so the select opens once cnt+1 reaches BLANK_CYCLES.
        sel_on = shown_n & ~tick & (cnt >= BLANK_LAST);
`else
        sel_on = shown_n;
`endif
        sel_n = sel_on ? ((4'b0001 << slot_n) ^ SEL_OFF) : SEL_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            slot        <= 2'd3;
            shown       <= 1'b0;
            seg         <= SEG_OFF;
            dp          <= SEG_ACTIVE_LOW;
            digit_sel   <= SEL_OFF;
            frame_start <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            slot        <= slot_n;
            shown       <= shown_n;
            seg         <= seg_n;
            dp          <= dp_n;
            digit_sel   <= sel_n;
            frame_start <= fs_n;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// tb/tb_sev_seg_scan_driver.sv - scoreboard bench for sev_seg_scan_driver
module tb_sev_seg_scan_driver;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYCLES = 1;
`ifdef SEV_SEG_GHOST_BLANK_EN
    localparam logic [3:0] SEL_SLOT0 = 4'hF;
    localparam logic [3:0] SEL_SLOT3 = 4'hF;
`else
    localparam logic [3:0] SEL_SLOT0 = 4'hE;
    localparam logic [3:0] SEL_SLOT3 = 4'h7;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [6:0] digit_0 = 7'h3F, digit_1 = 7'h06, digit_2 = 7'h5B, digit_3 = 7'h4F;
    logic [3:0] dots = 4'b0001;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] digit_sel;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];
    logic [12:0] got, e;
    int          m_cnt = 0, m_slot = 3;
    bit          m_show = 0;
    logic [6:0]  m_seg = 7'h7F;
    logic        m_dp = 1'b1, m_fs = 1'b0;
    logic [3:0]  m_sel = 4'hF;

    always #5 clk = ~clk;

    sev_seg_scan_driver #(
        .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
        .dots(dots), .seg(seg), .dp(dp), .digit_sel(digit_sel), .frame_start(frame_start)
    );

    function automatic logic [6:0] dig(int s);
        case (s)
            1:       return digit_1;
            2:       return digit_2;
            3:       return digit_3;
            default: return digit_0;
        endcase
    endfunction

    // Reference model: pushes the expected registered outputs for every clock edge.
    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cnt = 0; m_slot = 3; m_show = 0; m_seg = 7'h7F; m_dp = 1'b1;
            exp_q.delete();
        end else begin
            m_fs = 1'b0;
            if (m_cnt == SCAN_DIV - 1) begin
                m_cnt = 0; m_slot = (m_slot + 1) % 4; m_show = en; m_fs = (m_slot == 0);
                if (m_show) begin m_seg = ~dig(m_slot); m_dp = ~dots[m_slot]; end
            end else begin
                m_cnt++; m_show = m_show && en;
            end
            if (!m_show) begin m_seg = 7'h7F; m_dp = 1'b1; end
            m_sel = m_show ? ~(4'b0001 << m_slot) : 4'hF;
`ifdef SEV_SEG_GHOST_BLANK_EN
            if (m_cnt < BLANK_CYCLES) m_sel = 4'hF;
`endif
            exp_q.push_back({m_sel, m_seg, m_dp, m_fs});
        end
    end

    task automatic test_reset();
        #1 rst = 1'b1;
        en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({digit_sel, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_state: got %h expected %h", {digit_sel, seg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
            end
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_first_frame(string name);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            got = {digit_sel, seg, dp, frame_start};
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL %s_sb: got no expected entry, required one", name);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin errors++; $display("FAIL %s_sb[%0d]: got %h expected %h", name, i, got, e); end
            end
            if (i == 4) begin
                checks++;
                if (got !== {SEL_SLOT0, 7'h40, 1'b0, 1'b1}) begin
                    errors++; $display("FAIL %s_edge4: got %h expected %h", name, got, {SEL_SLOT0, 7'h40, 1'b0, 1'b1});
                end
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] walk [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        int k = 0, npulse = 0, first = -1, second = -1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++;
            got = {digit_sel, seg, dp, frame_start};
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL scan_sb: got no expected entry, required one");
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin errors++; $display("FAIL scan_sb[%0d]: got %h expected %h", i, got, e); end
            end
            if (frame_start === 1'b1) begin
                npulse++;
                if (first < 0) first = i; else if (second < 0) second = i;
            end
            if (i % 4 == 2) begin
                checks++;
                if (digit_sel !== walk[k % 4]) begin
                    errors++; $display("FAIL scan_walk[%0d]: got %b expected %b", k, digit_sel, walk[k % 4]);
                end
                k++;
            end
        end
        checks++;
        if (npulse != 2 || second - first != 16) begin
            errors++; $display("FAIL frame_period: got %0d pulses %0d apart, expected 2 pulses 16 apart", npulse, second - first);
        end
    endtask

    task automatic wait_slot(string name, int slot, int cnt);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            checks++;
            got = {digit_sel, seg, dp, frame_start};
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL %s_wait_sb: got no expected entry, required one", name);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin errors++; $display("FAIL %s_wait_sb: got %h expected %h", name, got, e); end
            end
            found = (m_slot == slot || slot < 0) && m_cnt == cnt;
        end
        if (!found) begin
            errors++; $display("FAIL %s_timeout: got no slot %0d phase %0d within 40 cycles, required one", name, slot, cnt);
        end
    endtask

    task automatic test_hold();
        wait_slot("hold", 1, 1);
        digit_1 = 7'h5B;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            checks++;
            got = {digit_sel, seg, dp, frame_start};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 13'h1FFF;
            if (got !== e) begin errors++; $display("FAIL hold_sb[%0d]: got %h expected %h", j, got, e); end
            if (j < 2 || j == 14) begin
                checks++;
                if (seg !== ((j == 14) ? 7'h24 : 7'h79)) begin
                    errors++; $display("FAIL hold_seg[%0d]: got %h expected %h", j, seg, (j == 14) ? 7'h24 : 7'h79);
                end
            end
        end
    endtask

    task automatic test_enable();
        wait_slot("enable", 2, 1);
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j == 0) en = 1'b1;
            checks++;
            got = {digit_sel, seg, dp, frame_start};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 13'h1FFF;
            if (got !== e) begin errors++; $display("FAIL enable_sb[%0d]: got %h expected %h", j, got, e); end
            checks++;
            if (j < 2 && got !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                errors++; $display("FAIL enable_blank[%0d]: got %h expected %h", j, got, {4'hF, 7'h7F, 1'b1, 1'b0});
            end else if (j == 2 && got !== {SEL_SLOT3, 7'h30, 1'b1, 1'b0}) begin
                errors++; $display("FAIL enable_resume: got %h expected %h", got, {SEL_SLOT3, 7'h30, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_tick_fall();
        int slot_before;
        wait_slot("tickfall", -1, SCAN_DIV - 1);
        slot_before = m_slot;
        en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0) en = 1'b1;
            checks++;
            got = {digit_sel, seg, dp, frame_start};
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 13'h1FFF;
            if (got !== e) begin errors++; $display("FAIL tickfall_sb[%0d]: got %h expected %h", j, got, e); end
        end
        checks++;
        if (digit_sel !== ~(4'b0001 << ((slot_before + 2) % 4))) begin
            errors++; $display("FAIL tickfall_slot: got %b expected %b", digit_sel, ~(4'b0001 << ((slot_before + 2) % 4)));
        end
    endtask

    task automatic test_reset_mid();
        wait_slot("rstmid", 1, 1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({digit_sel, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rstmid_async: got %h expected %h", {digit_sel, seg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        test_first_frame("rstmid");
    endtask

    initial begin
        test_reset();
        test_first_frame("first");
        test_scan();
        test_hold();
        test_enable();
        test_tick_fall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
